// File: rtl/reg_bank_loader_pkg.sv
// Shared definitions for the register-bank loader: frame marker, instruction
// codes (same values the bank decodes), loader state encodings, instruction type.
package reg_bank_loader_pkg;

  localparam int INST_W = 12;

  localparam logic [3:0] HDR_MARK = 4'hC;

  localparam logic [3:0] CODE_NOP = 4'd0;
  localparam logic [3:0] CODE_LD0 = 4'd1;
  localparam logic [3:0] CODE_LD1 = 4'd2;
  localparam logic [3:0] CODE_LD2 = 4'd3;
  localparam logic [3:0] CODE_LD3 = 4'd4;
  localparam logic [3:0] CODE_LD4 = 4'd5;
  localparam logic [3:0] CODE_LD5 = 4'd6;
  localparam logic [3:0] CODE_LD6 = 4'd7;
  localparam logic [3:0] CODE_LD7 = 4'd8;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WAIT_DATA  = 3'd2,
    ST_WAIT_CHECK = 3'd3,
    ST_ERROR      = 3'd4
  } ld_state_e;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] imm;
  } inst_t;

  // Code field names a load that carries a data byte
  function automatic logic is_ld(input logic [3:0] c);
    case (c)
      CODE_LD0, CODE_LD1, CODE_LD2, CODE_LD3,
      CODE_LD4, CODE_LD5, CODE_LD6, CODE_LD7: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Header is well formed: marker nibble and a known code
  function automatic logic hdr_ok(input logic [7:0] b);
    return (b[7:4] == HDR_MARK) && ((b[3:0] == CODE_NOP) || is_ld(b[3:0]));
  endfunction

endpackage

// File: rtl/reg_bank_loader_timer.sv
// Inter-byte timeout counter. expired is combinational and fires in the cycle
// whose increment would make the count reach TIMEOUT_CYCLES; a clear in the
// same cycle suppresses it. TIMEOUT_CYCLES == 0 disables the timer entirely.
module reg_bank_loader_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam bit TO_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] LAST =
    TO_ON ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMEOUT_WIDTH-1:0] cnt;

  // Count idle wait cycles; clear wins over enable
  always_ff @(posedge clock) begin
    if (!reset)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && TO_ON) cnt <= cnt + 1'b1;
  end

  assign expired = TO_ON && en && !clr && (cnt == LAST);

endmodule

// File: rtl/reg_bank_loader.sv
// Byte-stream to bank-instruction loader. Parses {C,code} headers, collects the
// data byte for loads, times out stalled frames and locks up on a bad header
// until reset. Build option REG_BANK_LOADER_CHECK_EN adds a third checksum byte
// (header XOR data) to load frames.
module reg_bank_loader
  import reg_bank_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [INST_W-1:0]    inst,
  output logic                 inst_en,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 err_timeout,
  output logic                 err_check,
  output logic                 error
);

  ld_state_e state, state_nxt;

  logic       xfer, waiting;
  logic       tmr_clr, tmr_en, tmr_exp;
  logic       issue, drop_to;
  inst_t      issue_inst, inst_q;
  logic [3:0] code_q;
`ifdef REG_BANK_LOADER_CHECK_EN
  logic [7:0] imm_q;
  logic       drop_ck;
`endif

  assign xfer    = in_valid & in_ready;
  assign waiting = (state == ST_WAIT_DATA) || (state == ST_WAIT_CHECK);
  assign tmr_clr = !waiting || xfer;
  assign tmr_en  = waiting && !xfer;

  reg_bank_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_RESET;
    else        state <= state_nxt;
  end

  // Next-state: frame parsing; any unknown encoding collapses into Error
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (xfer) begin
          if (!hdr_ok(in_data))            state_nxt = ST_ERROR;
          else if (in_data[3:0] == CODE_NOP) state_nxt = ST_IDLE;
          else                             state_nxt = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
`ifdef REG_BANK_LOADER_CHECK_EN
        if (xfer)         state_nxt = ST_WAIT_CHECK;
`else
        if (xfer)         state_nxt = ST_IDLE;
`endif
        else if (tmr_exp) state_nxt = ST_IDLE;
      end
`ifdef REG_BANK_LOADER_CHECK_EN
      ST_WAIT_CHECK: begin
        if (xfer || tmr_exp) state_nxt = ST_IDLE;
      end
`endif
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_ERROR;
    endcase
  end

  // Outputs and per-cycle actions: handshake, issue and drop decisions
  always_comb begin
    in_ready   = 1'b0;
    error      = (state == ST_ERROR);
    issue      = 1'b0;
    issue_inst = '0;
    drop_to    = 1'b0;
`ifdef REG_BANK_LOADER_CHECK_EN
    drop_ck    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (xfer && hdr_ok(in_data) && (in_data[3:0] == CODE_NOP)) issue = 1'b1;
      end
      ST_WAIT_DATA: begin
        in_ready = 1'b1;
`ifdef REG_BANK_LOADER_CHECK_EN
        if (!xfer && tmr_exp) drop_to = 1'b1;
`else
        if (xfer) begin
          issue      = 1'b1;
          issue_inst = '{code: code_q, imm: in_data};
        end else if (tmr_exp) begin
          drop_to = 1'b1;
        end
`endif
      end
`ifdef REG_BANK_LOADER_CHECK_EN
      ST_WAIT_CHECK: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (in_data == ({HDR_MARK, code_q} ^ imm_q)) begin
            issue      = 1'b1;
            issue_inst = '{code: code_q, imm: imm_q};
          end else begin
            drop_ck = 1'b1;
          end
        end else if (tmr_exp) begin
          drop_to = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath: frame fields, registered strobes, held instruction, saturating count
  always_ff @(posedge clock) begin
    if (!reset) begin
      inst_q      <= '0;
      inst_en     <= 1'b0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
      code_q      <= '0;
`ifdef REG_BANK_LOADER_CHECK_EN
      imm_q       <= '0;
      err_check   <= 1'b0;
`endif
    end else begin
      inst_en     <= issue;
      err_timeout <= drop_to;
`ifdef REG_BANK_LOADER_CHECK_EN
      err_check   <= drop_ck;
      if (state == ST_WAIT_DATA && xfer) imm_q <= in_data;
`endif
      if (state == ST_IDLE && xfer) code_q <= in_data[3:0];
      if (issue) begin
        inst_q <= issue_inst;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

`ifndef REG_BANK_LOADER_CHECK_EN
  assign err_check = 1'b0;
`endif

  assign inst = inst_q;

endmodule

// File: tb/tb_reg_bank_loader.sv
// Randomized bench for reg_bank_loader. A frame-level reference model (byte
// queue per frame, idle-cycle count) predicts every output each cycle.
module tb_reg_bank_loader;

  localparam int TO = 4;
  localparam int CW = 4;
`ifdef REG_BANK_LOADER_CHECK_EN
  localparam int LDLEN = 3;
`else
  localparam int LDLEN = 2;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   inst;
  logic          inst_en;
  logic [CW-1:0] frame_cnt;
  logic          err_timeout, err_check, error;

  always #5 clock = ~clock;

  reg_bank_loader #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_WIDTH (4),
    .CNT_WIDTH     (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst       (inst),
    .inst_en    (inst_en),
    .frame_cnt  (frame_cnt),
    .err_timeout(err_timeout),
    .err_check  (err_check),
    .error      (error)
  );

  int nchk = 0;
  int nerr = 0;

  // reference model state (post-edge expectations)
  bit            m_started = 0, m_err = 0, m_rdy = 0;
  logic [11:0]   m_inst = '0;
  logic          m_en = 0, m_to = 0, m_ck = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [7:0]    frm[$];
  int            idle = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_issue(input logic [11:0] v);
    m_inst = v;
    m_en   = 1'b1;
    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
  endtask

  // one clock of the frame-level model; acc tells whether the byte was taken
  task automatic model_step(input logic v, input logic [7:0] d, output bit acc);
    acc  = v && m_rdy;
    m_en = 0; m_to = 0; m_ck = 0;
    if (!reset) begin
      m_started = 0; m_err = 0; m_inst = '0; m_cnt = '0; frm.delete(); idle = 0;
    end else if (m_err) begin
    end else if (!m_started) begin
      m_started = 1;
    end else if (acc) begin
      frm.push_back(d);
      idle = 0;
      if (frm.size() == 1) begin
        if (d[7:4] != 4'hC || d[3:0] > 4'd8) begin m_err = 1; frm.delete(); end
        else if (d[3:0] == 4'd0) begin m_issue(12'h000); frm.delete(); end
      end else if (frm.size() == LDLEN) begin
        if (LDLEN == 3 && frm[LDLEN-1] != (frm[0] ^ frm[1])) m_ck = 1;
        else m_issue({frm[0][3:0], frm[1]});
        frm.delete();
      end
    end else if (frm.size() > 0) begin
      idle++;
      if (idle == TO) begin m_to = 1; frm.delete(); end
    end
    m_rdy = reset && m_started && !m_err;
  endtask

  task automatic check_outs();
    chk("in_ready",    32'(in_ready),    32'(m_rdy));
    chk("inst",        32'(inst),        32'(m_inst));
    chk("inst_en",     32'(inst_en),     32'(m_en));
    chk("frame_cnt",   32'(frame_cnt),   32'(m_cnt));
    chk("err_timeout", 32'(err_timeout), 32'(m_to));
    chk("err_check",   32'(err_check),   32'(m_ck));
    chk("error",       32'(error),       32'(m_err));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, output bit acc);
    in_valid = v;
    in_data  = d;
    model_step(v, d, acc);
    @(posedge clock);
    @(negedge clock);
    check_outs();
  endtask

  task automatic idle_cyc(input int n);
    bit a;
    repeat (n) cyc(1'b0, 8'($urandom), a);
  endtask

  task automatic do_reset();
    bit a;
    reset = 1'b0;
    cyc(1'b0, 8'h00, a);
    cyc(1'b1, 8'($urandom), a);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    bit a;
    idle_cyc(gap);
    if (m_err) return;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, d, a);
      if (a) return;
    end
    chk("accept_bound", 32'd0, 32'd1);
  endtask

  int gap_r;
  function automatic int rgap();
    return ($urandom_range(0, 7) == 0) ? TO - 1 + int'($urandom_range(0, 2))
                                       : int'($urandom_range(0, 1));
  endfunction

  initial begin
    logic [7:0] hdr, dat, ck;
    bit a;
    @(negedge clock);
    cyc(1'b0, 8'h00, a);
    cyc(1'b1, 8'hC0, a);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_cnt",   32'(frame_cnt), 32'd0);
    reset = 1'b1;

    // back-to-back load
    send_byte(8'hC3, 0); send_byte(8'h5A, 0);
    chk("t1_inst", 32'(inst), 32'h35A);
    chk("t1_en",   32'(inst_en), 32'd1);
    chk("t1_cnt",  32'(frame_cnt), 32'd1);

    // NOP then LD7 after fresh reset
    do_reset();
    send_byte(8'hC0, 0);
    chk("t2_nop", 32'(inst), 32'h000);
    send_byte(8'hC8, 0); send_byte(8'hFF, 0);
    chk("t2_inst", 32'(inst), 32'h8FF);
    chk("t2_cnt",  32'(frame_cnt), 32'd2);

    // frame counter saturation
    repeat (20) send_byte(8'hC0, 0);
    chk("sat_cnt", 32'(frame_cnt), 32'hF);

    // bad header locks up until reset
    do_reset();
    send_byte(8'h7F, 0);
    chk("t3_err", 32'(error), 32'd1);
    chk("t3_rdy", 32'(in_ready), 32'd0);
    repeat (3) cyc(1'b1, 8'hC1, a);
    do_reset();
    chk("t3_clr", 32'(error), 32'd0);
    idle_cyc(1);

    // timeout, then transfer landing on the expiry cycle
    send_byte(8'hC2, 0);
    idle_cyc(TO - 1);
    chk("t4_pre", 32'(err_timeout), 32'd0);
    idle_cyc(1);
    chk("t4_to", 32'(err_timeout), 32'd1);
    send_byte(8'hC2, 0); send_byte(8'h11, TO - 1);
    chk("t4_inst", 32'(inst), 32'h211);
    chk("t4_en",   32'(inst_en), 32'd1);

`ifdef REG_BANK_LOADER_CHECK_EN
    send_byte(8'hC5, 0); send_byte(8'h3C, 0); send_byte(8'hF9, 0);
    chk("t5_inst", 32'(inst), 32'h53C);
    send_byte(8'hC5, 0); send_byte(8'h3C, 0); send_byte(8'h00, 0);
    chk("t5_ck", 32'(err_check), 32'd1);
`endif

    // reset mid-frame discards the header
    send_byte(8'hC4, 0);
    do_reset();
    send_byte(8'h77, 0);
    chk("t6_err", 32'(error), 32'd1);
    chk("t6_en",  32'(inst_en), 32'd0);

    // random frames with gaps, junk headers, corruption and resets
    do_reset();
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      hdr = {4'hC, 4'($urandom_range(0, 8))};
      if ($urandom_range(0, 15) == 0) hdr = 8'($urandom);
      send_byte(hdr, rgap());
      if (hdr[7:4] == 4'hC && hdr[3:0] >= 4'd1 && hdr[3:0] <= 4'd8) begin
        if ($urandom_range(0, 24) == 0) do_reset();
        else begin
          dat = 8'($urandom);
          send_byte(dat, rgap());
          if (LDLEN == 3) begin
            ck = hdr ^ dat;
            if ($urandom_range(0, 5) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            send_byte(ck, rgap());
          end
        end
      end
      if (m_err) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
